// File: rtl/tsc_pkg.sv
// Shared types and defaults for the turn-signal conditioner.
package tsc_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned CNT_W_DEF           = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RISE_WAIT = 2'd1,
        ON        = 2'd2,
        FALL_WAIT = 2'd3
    } deb_state_e;

    // A channel reads as stably high until a fall has been fully confirmed.
    function automatic logic is_stable_high(input deb_state_e s);
        return (s == ON) || (s == FALL_WAIT);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchronizer, saturating counter and debounce FSM.
module debounce_channel
    import tsc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_q1;
    logic             sync_q2;
    deb_state_e       state;
    deb_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             stable_next;

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            stable <= stable_next;
        end
    end

    // The limit is checked before incrementing, so DEBOUNCE_CYCLES synced
    // samples are counted before the state flips.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (sync_q2) begin
                    state_next = RISE_WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            RISE_WAIT: begin
                if (!sync_q2) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt >= CNT_LIMIT) begin
                    state_next = ON;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ON: begin
                if (!sync_q2) begin
                    state_next = FALL_WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            FALL_WAIT: begin
                if (sync_q2) begin
                    state_next = ON;
                    cnt_next   = '0;
                end else if (cnt >= CNT_LIMIT) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        stable_next = is_stable_high(state_next);
    end

endmodule

// File: rtl/turn_signal_conditioner.sv
// Debounces turn/hazard switches and arbitrates them into registered lamp requests.
// Define TSC_HAZARD_EN to build the hazard channel and its priority.
module turn_signal_conditioner
    import tsc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_left_raw,
    input  logic sw_right_raw,
    input  logic sw_hazard_raw,
    output logic left,
    output logic right,
    output logic conflict
);

    logic left_stable;
    logic right_stable;
    logic left_next;
    logic right_next;
    logic conflict_next;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_left (
        .clk    (clk),
        .reset  (reset),
        .raw    (sw_left_raw),
        .stable (left_stable)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_right (
        .clk    (clk),
        .reset  (reset),
        .raw    (sw_right_raw),
        .stable (right_stable)
    );

`ifdef TSC_HAZARD_EN
    logic hazard_stable;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_hazard (
        .clk    (clk),
        .reset  (reset),
        .raw    (sw_hazard_raw),
        .stable (hazard_stable)
    );
`else
    logic hazard_unused;
    assign hazard_unused = sw_hazard_raw;
`endif

    // Later assignments override earlier ones, giving hazard the top priority.
    always_comb begin
        left_next     = left_stable;
        right_next    = right_stable;
        conflict_next = 1'b0;
        if (left_stable && right_stable) begin
            left_next     = 1'b0;
            right_next    = 1'b0;
            conflict_next = 1'b1;
        end
`ifdef TSC_HAZARD_EN
        if (hazard_stable) begin
            left_next     = 1'b1;
            right_next    = 1'b1;
            conflict_next = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left     <= 1'b0;
            right    <= 1'b0;
            conflict <= 1'b0;
        end else begin
            left     <= left_next;
            right    <= right_next;
            conflict <= conflict_next;
        end
    end

endmodule

// File: doc/turn_signal_conditioner.md
TURN_SIGNAL_CONDITIONER -- requirements
Module: turn_signal_conditioner

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high; ports are named clk and reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, SHALL be the number of consecutive stable cycles required to accept a switch change (range 1..2^CNT_W-1).
REQ-003 Parameter CNT_W, default 8, SHALL be the debounce counter width.
REQ-004 Port clk, input, 1, SHALL be the system clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, SHALL be the asynchronous active-high reset.
REQ-006 Port sw_left_raw, input, 1, SHALL be the asynchronous, bouncing left turn switch.
REQ-007 Port sw_right_raw, input, 1, SHALL be the asynchronous, bouncing right turn switch.
REQ-008 Port sw_hazard_raw, input, 1, SHALL be the asynchronous, bouncing hazard switch.
REQ-009 Port left, output, 1, SHALL be the conditioned left request to the tail-lamp FSM.
REQ-010 Port right, output, 1, SHALL be the conditioned right request to the tail-lamp FSM.
REQ-011 Port conflict, output, 1, SHALL flag that left and right are both stably on without hazard.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each channel SHALL run a debounce FSM: IDLE (stable 0), RISE_WAIT, ON (stable 1), FALL_WAIT.
REQ-014 IDLE -> RISE_WAIT when synced input is 1, counter loaded to 1.
REQ-015 RISE_WAIT: synced 1 increments counter; counter reaching DEBOUNCE_CYCLES -> ON; synced 0 -> IDLE, counter cleared.
REQ-016 ON -> FALL_WAIT when synced input is 0; FALL_WAIT mirrors RISE_WAIT, ending in IDLE, or ON on a bounce back to 1.
REQ-017 Channel stable value SHALL be 1 in ON and FALL_WAIT, 0 in IDLE and RISE_WAIT.
REQ-018 Arbitration SHALL be priority: hazard stable -> left=1,right=1,conflict=0; else left and right both stable -> left=0,right=0,conflict=1; else left, right follow their stable values, conflict=0.
REQ-019 left, right, conflict SHALL be registered outputs, glitch-free.
REQ-020 Latency from a clean raw edge (set before rising edge 0) to output change SHALL be exactly 2+DEBOUNCE_CYCLES+1 rising edges (edge 7 for default).
REQ-021 A pulse shorter than DEBOUNCE_CYCLES synced cycles SHALL produce no output change.
REQ-022 Counter SHALL saturate, never wrap; DEBOUNCE_CYCLES=1 accepts a change after one synced cycle.
REQ-023 Simultaneous acceptance on several channels in one cycle SHALL be resolved by REQ-018 in that same output update.

Reset
REQ-024 Reset SHALL clear synchronizer flops, counters, FSMs (IDLE), and set left=0, right=0, conflict=0 immediately, independent of clk.
REQ-025 Reset asserted mid-debounce SHALL discard partial counts; after release, inputs held high SHALL take full REQ-020 latency.

Configuration
REQ-026 Macro TSC_HAZARD_EN defined: hazard channel and its priority SHALL be implemented per REQ-018.
REQ-027 Macro TSC_HAZARD_EN undefined: sw_hazard_raw port SHALL remain but be ignored; no hazard channel logic; arbitration uses only left/right rules.

Structure
REQ-028 Shared package tsc_pkg SHALL hold the debounce state encoding (IDLE, RISE_WAIT, ON, FALL_WAIT) and default DEBOUNCE_CYCLES/CNT_W constants.
REQ-029 Sub-module debounce_channel (synchronizer + counter + FSM, output stable) SHALL be instantiated once per channel.
REQ-030 Arbitration and output registers SHALL reside in the top module.

Verification
REQ-031 Clean: reset, release, sw_left_raw 0->1 held -> left=1 on edge 7, right=0, conflict=0.
REQ-032 Bounce: sw_right_raw high 3 cycles, low 1, high held -> right stays 0 until 7 edges after final rise.
REQ-033 Conflict: left and right both held -> conflict=1, left=0, right=0; release right -> left=1, conflict=0 after 7 edges.
REQ-034 Hazard (TSC_HAZARD_EN): hazard held with left on -> left=1, right=1, conflict=0; hazard released -> right=0 after 7 edges; without macro, hazard input has no effect.
REQ-035 Reset mid-operation: left ON, assert reset between clock edges -> outputs 0 immediately; release with left high -> left=1 on edge 7.
